// File: rtl/axis_adder_pkg.sv
// Shared definitions for the AXI-Stream two-input adder.
//   sum_width()    : width of an exact sum of two WIDTH-bit operands
//   PIPE_DEPTH     : number of register slices between the join and the master port
//   *_MODE         : encodings for the SIGNED parameter of axis_adder_join
package axis_adder_pkg;

    localparam int unsigned PIPE_DEPTH    = 2;
    localparam int unsigned UNSIGNED_MODE = 0;
    localparam int unsigned SIGNED_MODE   = 1;

    // One extra bit makes the sum of two equally wide operands exact.
    function automatic int unsigned sum_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/axis_pipe_stage.sv
// One elastic register slice with valid/ready handshake on both sides.
//   clk          : clock, rising edge
//   reset_n      : synchronous reset, active low; drops valid and zeroes the payload
//   in_valid_i   : upstream beat valid
//   in_ready_o   : slice can take a beat this cycle (0 while in reset)
//   in_data_i    : upstream payload
//   out_valid_o  : slice holds a beat
//   out_ready_i  : downstream takes the beat this cycle
//   out_data_o   : held payload, stable while out_valid_o & !out_ready_i
module axis_pipe_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    // Ready only depends on our own state and the downstream ready, so a full
    // chain of slices forms a purely combinational ready path.
    assign in_ready_o = reset_n & (~valid_q | out_ready_i);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            // Either hand off (or stay empty) and take whatever upstream offers.
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/axis_adder_join.sv
// Joins one beat from each of two AXI-Stream slaves and emits their exact sum
// on a master stream through a two-slice elastic pipeline.
//   clk, reset_n            : clock and synchronous active-low reset
//   s0_tvalid/tready/tdata  : operand A stream, s0_tlast carried to m_tlast
//   s1_tvalid/tready/tdata  : operand B stream
//   m_tvalid/tready/tdata   : WIDTH+1-bit sum stream, m_tlast from s0_tlast
// SIGNED selects zero- (UNSIGNED_MODE) or sign-extension (SIGNED_MODE).
module axis_adder_join
    import axis_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SIGNED = UNSIGNED_MODE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s0_tvalid,
    output logic             s0_tready,
    input  logic [WIDTH-1:0] s0_tdata,
    input  logic             s0_tlast,
    input  logic             s1_tvalid,
    output logic             s1_tready,
    input  logic [WIDTH-1:0] s1_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH:0]   m_tdata,
    output logic             m_tlast
);

    localparam int unsigned SumW = sum_width(WIDTH);
    localparam int unsigned St1W = 2 * SumW + 1;
    localparam int unsigned St2W = SumW + 1;

    logic [SumW-1:0] op_a_ext, op_b_ext;
    logic [SumW-1:0] st1_a, st1_b, sum;
    logic            st1_last;
    logic            st1_in_valid, st1_ready;
    logic            st1_valid, st2_ready;

    always_comb begin
        if (SIGNED == SIGNED_MODE) begin
            op_a_ext = {s0_tdata[WIDTH-1], s0_tdata};
            op_b_ext = {s1_tdata[WIDTH-1], s1_tdata};
        end else begin
            op_a_ext = {1'b0, s0_tdata};
            op_b_ext = {1'b0, s1_tdata};
        end
    end

    // Each side's ready waits on the other side's valid, so a lone beat is
    // never consumed and both streams always advance together.
    assign st1_in_valid = s0_tvalid & s1_tvalid;
    assign s0_tready    = s1_tvalid & st1_ready;
    assign s1_tready    = s0_tvalid & st1_ready;

    axis_pipe_stage #(
        .Width (St1W)
    ) u_stage1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (st1_in_valid),
        .in_ready_o  (st1_ready),
        .in_data_i   ({op_a_ext, op_b_ext, s0_tlast}),
        .out_valid_o (st1_valid),
        .out_ready_i (st2_ready),
        .out_data_o  ({st1_a, st1_b, st1_last})
    );

    // Operands are already extended to SumW bits, so this add cannot wrap.
    assign sum = st1_a + st1_b;

    axis_pipe_stage #(
        .Width (St2W)
    ) u_stage2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (st1_valid),
        .in_ready_o  (st2_ready),
        .in_data_i   ({sum, st1_last}),
        .out_valid_o (m_tvalid),
        .out_ready_i (m_tready),
        .out_data_o  ({m_tdata, m_tlast})
    );

endmodule

// File: tb/tb_axis_adder_join.sv
// Drives an unsigned and a signed instance with identical streams and checks
// both against a queue-based model of the pipeline.
module tb_axis_adder_join;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s0_tvalid, s1_tvalid, s0_tlast, m_tready;
    logic [W-1:0] s0_tdata, s1_tdata;

    logic         u_s0_tready, u_s1_tready, u_m_tvalid, u_m_tlast;
    logic [W:0]   u_m_tdata;
    logic         s_s0_tready, s_s1_tready, s_m_tvalid, s_m_tlast;
    logic [W:0]   s_m_tdata;

    always #5 clk = ~clk;

    axis_adder_join #(.WIDTH(W), .SIGNED(0)) dut_u (
        .clk (clk), .reset_n (reset_n),
        .s0_tvalid (s0_tvalid), .s0_tready (u_s0_tready), .s0_tdata (s0_tdata),
        .s0_tlast (s0_tlast),
        .s1_tvalid (s1_tvalid), .s1_tready (u_s1_tready), .s1_tdata (s1_tdata),
        .m_tvalid (u_m_tvalid), .m_tready (m_tready), .m_tdata (u_m_tdata),
        .m_tlast (u_m_tlast)
    );

    axis_adder_join #(.WIDTH(W), .SIGNED(1)) dut_s (
        .clk (clk), .reset_n (reset_n),
        .s0_tvalid (s0_tvalid), .s0_tready (s_s0_tready), .s0_tdata (s0_tdata),
        .s0_tlast (s0_tlast),
        .s1_tvalid (s1_tvalid), .s1_tready (s_s1_tready), .s1_tdata (s1_tdata),
        .m_tvalid (s_m_tvalid), .m_tready (m_tready), .m_tdata (s_m_tdata),
        .m_tlast (s_m_tlast)
    );

    typedef struct {
        int   a;
        int   b;
        logic last;
    } pair_t;

    typedef struct {
        logic [W:0] su;
        logic [W:0] ss;
        logic       last;
        int         acc;  // edge at which the pair was accepted
        int         vis;  // first edge after which it is on the output (valid for head)
    } beat_t;

    pair_t src_q[$];
    beat_t exp_q[$];
    int    edge_cnt = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    bit    en0 = 1'b1;
    bit    en1 = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic int sext(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    task automatic push(input int a, input int b, input logic last);
        pair_t p;
        p.a = a; p.b = b; p.last = last;
        src_q.push_back(p);
    endtask

    // One clock cycle: present sources, check at negedge, advance model at posedge.
    task automatic step();
        bit    fire_in, fire_out, exp_v, exp_rdy;
        beat_t bt;
        s0_tvalid = en0 && (src_q.size() > 0);
        s1_tvalid = en1 && (src_q.size() > 0);
        if (src_q.size() > 0) begin
            s0_tdata = W'(src_q[0].a);
            s1_tdata = W'(src_q[0].b);
            s0_tlast = src_q[0].last;
        end
        @(negedge clk);
        // At most two beats in flight; with one or none there is always room.
        exp_rdy = reset_n && ((exp_q.size() < 2) || m_tready);
        exp_v   = (exp_q.size() > 0) && (exp_q[0].vis <= edge_cnt);
        check("s0_tready_u", u_s0_tready, exp_rdy & s1_tvalid);
        check("s1_tready_u", u_s1_tready, exp_rdy & s0_tvalid);
        check("s0_tready_s", s_s0_tready, exp_rdy & s1_tvalid);
        check("s1_tready_s", s_s1_tready, exp_rdy & s0_tvalid);
        check("m_tvalid_u", u_m_tvalid, exp_v);
        check("m_tvalid_s", s_m_tvalid, exp_v);
        if (exp_v) begin
            check("m_tdata_u", u_m_tdata, exp_q[0].su);
            check("m_tdata_s", s_m_tdata, exp_q[0].ss);
            check("m_tlast_u", u_m_tlast, exp_q[0].last);
            check("m_tlast_s", s_m_tlast, exp_q[0].last);
        end
        fire_in  = s0_tvalid && s1_tvalid && exp_rdy;
        fire_out = exp_v && m_tready && reset_n;
        @(posedge clk);
        edge_cnt++;
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (fire_out) begin
                void'(exp_q.pop_front());
                if (exp_q.size() > 0) begin
                    exp_q[0].vis = (exp_q[0].acc + 1 > edge_cnt) ? exp_q[0].acc + 1 : edge_cnt;
                end
            end
            if (fire_in) begin
                bt.su   = (W + 1)'(src_q[0].a + src_q[0].b);
                bt.ss   = (W + 1)'(sext(src_q[0].a) + sext(src_q[0].b));
                bt.last = src_q[0].last;
                bt.acc  = edge_cnt;
                bt.vis  = edge_cnt + 1;
                exp_q.push_back(bt);
                void'(src_q.pop_front());
            end
        end
        #1;
    endtask

    // mode 0: sink always ready; 1: ready pattern 1,0,0,1; 2: random sink and sources
    task automatic drain(input int mode, input int budget);
        int cyc = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: begin
                    m_tready = 1'($urandom_range(0, 1));
                    en0      = ($urandom_range(0, 3) != 0);
                    en1      = ($urandom_range(0, 3) != 0);
                end
            endcase
            step();
            cyc++;
        end
        en0 = 1'b1;
        en1 = 1'b1;
        check("drain_timeout", 32'(cyc >= budget), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        s0_tdata  = '0;   s1_tdata  = '0;
        s0_tlast  = 1'b0; m_tready  = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        check("reset_tdata_u", u_m_tdata, 0);
        check("reset_tdata_s", s_m_tdata, 0);
        check("reset_tlast_u", u_m_tlast, 0);
        reset_n = 1'b1;

        // Basic pairs.
        push(4, 1, 0);
        push(9, 3, 0);
        drain(0, 20);

        // s0 waits alone for three cycles before s1 shows up.
        push(7, 2, 0);
        en1 = 1'b0;
        m_tready = 1'b1;
        repeat (3) step();
        en1 = 1'b1;
        drain(0, 20);

        // Back-to-back beats against a toggling sink.
        for (int i = 0; i < 8; i++) push($urandom_range(0, 15), $urandom_range(0, 15), 0);
        drain(1, 100);

        // Extremes: 15+15, 8+8 (-8+-8 signed), 7+7.
        push(15, 15, 0);
        push(8, 8, 0);
        push(7, 7, 0);
        drain(0, 20);

        // Three-beat packet, last on the third beat.
        push(1, 2, 0);
        push(3, 4, 0);
        push(5, 6, 1);
        drain(1, 40);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            push($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
        drain(2, 2000);

        // Fill the pipe against a stalled sink, then reset mid-stall.
        m_tready = 1'b0;
        push(2, 3, 0);
        push(4, 5, 1);
        push(6, 7, 0);
        repeat (5) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        src_q.delete();
        m_tready = 1'b1;
        repeat (5) step();
        push(3, 4, 1);
        drain(0, 20);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
